// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified instruction/data RAM between the fetch
// stage (IF, read-only) and the memory stage (MEM, load/store). One access is
// in flight at a time; each access runs IDLE/RESP -> ISSUE -> WAIT (LAT
// cycles) -> RESP, so an access takes LAT+2 cycles from request to pulse.
// Also produces the pipeline freeze/stall controls that accompany the hazard
// unit's outputs.
//
// Optional build macro: MEM_ARB_PERF_EN adds two saturating 16-bit stall
// counters (fetch_stall_cnt, mem_stall_cnt). Without it those ports do not
// exist and behaviour is otherwise identical.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_valid) and address
//   if_rdata/if_valid   fetched word and its one-cycle completion pulse
//   mem_rd/mem_wr       load / store request (both high = store)
//   mem_addr/mem_wdata  load/store address and store data
//   mem_rdata/mem_done  load data (changes only on a completing load) and
//                       one-cycle completion pulse
//   ram_en/ram_we       RAM strobe (one cycle per access) and write enable
//   ram_addr/ram_wdata  RAM address and write data
//   ram_rdata           RAM read data, valid LAT cycles after ram_en
//   pc_writebar         blocks the PC update
//   IF_ID_loadbar       holds the IF/ID register
//   pipe_freeze         holds ID/EX, EX/MEM and MEM/WB
//   if_bubble           loads a NOP into IF/ID while fetch alone is stalled
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 19,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pc_writebar,
    output logic              IF_ID_loadbar,
    output logic              pipe_freeze,
    output logic              if_bubble
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       fetch_stall_cnt,
    output logic [15:0]       mem_stall_cnt
`endif
);

    // Final WAIT count before the read data is valid (LAT is 1..7).
    localparam logic [2:0] LAT_LAST = 3'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  wait_cnt_r;
    logic        last_mem_r;   // previous grant went to MEM
    logic        own_mem_r;    // current access belongs to MEM
    logic        own_wr_r;     // current access is a store

    logic        mem_req_s;
    logic        if_pend_s;
    logic        mem_pend_s;
    logic        grant_s;
    logic        grant_mem_s;
    logic        resp_entry_s;

    // Next-state logic and arbitration.
    always_comb begin
        state_s      = state_r;
        grant_s      = 1'b0;
        grant_mem_s  = 1'b0;
        mem_req_s    = mem_rd | mem_wr;
        if_pend_s    = if_req;
        mem_pend_s   = mem_req_s;
        resp_entry_s = (state_r == ST_WAIT) && (wait_cnt_r == LAT_LAST);

        // In RESP the owner's request is the one being answered right now;
        // its requester may still hold it this cycle, so it is not a new
        // request and must not be reissued with a stale address.
        if (state_r == ST_RESP) begin
            if (own_mem_r) begin
                mem_pend_s = 1'b0;
            end else begin
                if_pend_s  = 1'b0;
            end
        end else begin
            mem_pend_s = mem_req_s;
        end

        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (if_pend_s || mem_pend_s) begin
                    grant_s     = 1'b1;
                    // MEM wins unless it had the last grant and IF is waiting.
                    grant_mem_s = mem_pend_s && !(last_mem_r && if_pend_s);
                    state_s     = ST_ISSUE;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_entry_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // WAIT-phase latency counter; restarts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= 3'd0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
        end else begin
            wait_cnt_r <= 3'd0;
        end
    end

    // Grant bookkeeping and RAM command registers, loaded on the ISSUE entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_mem_r <= 1'b0;
            own_mem_r  <= 1'b0;
            own_wr_r   <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= {ADDR_W{1'b0}};
            ram_wdata  <= {DATA_W{1'b0}};
        end else begin
            ram_en <= grant_s;
            ram_we <= grant_s & grant_mem_s & mem_wr;
            if (grant_s) begin
                last_mem_r <= grant_mem_s;
                own_mem_r  <= grant_mem_s;
                own_wr_r   <= grant_mem_s & mem_wr;
                ram_addr   <= grant_mem_s ? mem_addr : if_addr;
                ram_wdata  <= (grant_mem_s && mem_wr) ? mem_wdata : ram_wdata;
            end else begin
                last_mem_r <= last_mem_r;
                own_mem_r  <= own_mem_r;
                own_wr_r   <= own_wr_r;
                ram_addr   <= ram_addr;
                ram_wdata  <= ram_wdata;
            end
        end
    end

    // Response capture: only the owner's pulse and data register change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid  <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= {DATA_W{1'b0}};
            mem_rdata <= {DATA_W{1'b0}};
        end else begin
            if_valid <= resp_entry_s & ~own_mem_r;
            mem_done <= resp_entry_s & own_mem_r;
            if (resp_entry_s && !own_mem_r) begin
                if_rdata <= ram_rdata;
            end else begin
                if_rdata <= if_rdata;
            end
            if (resp_entry_s && own_mem_r && !own_wr_r) begin
                mem_rdata <= ram_rdata;
            end else begin
                mem_rdata <= mem_rdata;
            end
        end
    end

    // Stall controls are combinational so the pipeline reacts in the same
    // cycle a request appears or completes.
    assign pipe_freeze   = mem_req_s & ~mem_done;
    assign IF_ID_loadbar = pipe_freeze;
    assign pc_writebar   = pipe_freeze | (if_req & ~if_valid);
    assign if_bubble     = if_req & ~if_valid & ~pipe_freeze;

`ifdef MEM_ARB_PERF_EN
    // Saturating stall-cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_stall_cnt <= 16'h0000;
            mem_stall_cnt   <= 16'h0000;
        end else begin
            if (pc_writebar && !pipe_freeze && (fetch_stall_cnt != 16'hFFFF)) begin
                fetch_stall_cnt <= fetch_stall_cnt + 16'h0001;
            end else begin
                fetch_stall_cnt <= fetch_stall_cnt;
            end
            if (pipe_freeze && (mem_stall_cnt != 16'hFFFF)) begin
                mem_stall_cnt <= mem_stall_cnt + 16'h0001;
            end else begin
                mem_stall_cnt <= mem_stall_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by randomized IF/MEM traffic. Expected
// behaviour comes from a transaction-level model: each grant is an access
// record with an issue cycle (grant+1) and a completion cycle (grant+LAT+2),
// an architectural memory image, and the stall equations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 19;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              pc_writebar;
    logic              IF_ID_loadbar;
    logic              pipe_freeze;
    logic              if_bubble;
`ifdef MEM_ARB_PERF_EN
    logic [15:0]       fetch_stall_cnt;
    logic [15:0]       mem_stall_cnt;
    int                exp_fs;
    int                exp_ms;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
`ifdef MEM_ARB_PERF_EN
        .fetch_stall_cnt(fetch_stall_cnt),
        .mem_stall_cnt  (mem_stall_cnt),
`endif
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .pc_writebar  (pc_writebar),
        .IF_ID_loadbar(IF_ID_loadbar),
        .pipe_freeze  (pipe_freeze),
        .if_bubble    (if_bubble)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM environment (fixed read latency) ----------------
    logic [DATA_W-1:0] ram_arr [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic              dl_v    [0:LAT];
    logic [ADDR_W-1:0] dl_a    [0:LAT];

    // Data for the read strobed LAT cycles earlier; garbage otherwise.
    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_a[i] = dl_a[i-1];
        end
        dl_v[0] = (ram_en === 1'b1) && (ram_we !== 1'b1);
        dl_a[0] = ram_addr;
        if ((ram_en === 1'b1) && (ram_we === 1'b1)) ram_arr[ram_addr] = ram_wdata;
        ram_rdata = (dl_v[LAT] === 1'b1) ? ram_arr[dl_a[LAT]] : DATA_W'($urandom);
    end

    // ---------------- transaction-level reference model ----------------
    int                cyc = 0;
    bit                busy = 1'b0;
    bit                t_mem, t_wr;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_data;
    int                t_issue, t_done;
    bit                last_mem = 1'b0;
    logic [DATA_W-1:0] exp_mem_rdata = '0;
    bit                if_done_prev = 1'b0;
    bit                mem_done_prev = 1'b0;

    // Requester state and directed-start requests.
    bit                if_active = 1'b0;
    logic [ADDR_W-1:0] if_a = '0;
    bit                mem_active = 1'b0;
    bit                m_rd, m_wr;
    logic [ADDR_W-1:0] m_a = '0;
    logic [DATA_W-1:0] m_d = '0;
    bit                go_if = 1'b0;
    logic [ADDR_W-1:0] go_if_a;
    bit                go_mem = 1'b0;
    bit                go_rd, go_wr;
    logic [ADDR_W-1:0] go_m_a;
    logic [DATA_W-1:0] go_m_d;
    logic              rst_val = 1'b0;

    task automatic model_check();
        bit e_ifv, e_md, e_en, mreq, pf, pi, pm;
        cyc++;
        mreq = mem_rd | mem_wr;
        if (!reset) begin
            busy = 1'b0; last_mem = 1'b0; exp_mem_rdata = '0;
            if_done_prev = 1'b0; mem_done_prev = 1'b0;
            check_eq("rst_ram_en",   ram_en,    0);
            check_eq("rst_ram_we",   ram_we,    0);
            check_eq("rst_if_valid", if_valid,  0);
            check_eq("rst_mem_done", mem_done,  0);
            check_eq("rst_ram_addr", ram_addr,  0);
            check_eq("rst_ram_wdata", ram_wdata, 0);
            check_eq("rst_if_rdata", if_rdata,  0);
            check_eq("rst_mem_rdata", mem_rdata, 0);
            check_eq("rst_pipe_freeze", pipe_freeze, mreq);
            check_eq("rst_pc_writebar", pc_writebar, mreq | if_req);
`ifdef MEM_ARB_PERF_EN
            exp_fs = 0; exp_ms = 0;
            check_eq("rst_fetch_cnt", fetch_stall_cnt, 0);
            check_eq("rst_mem_cnt",   mem_stall_cnt,   0);
`endif
            return;
        end
        e_ifv = busy && (t_done == cyc) && !t_mem;
        e_md  = busy && (t_done == cyc) && t_mem;
        e_en  = busy && (t_issue == cyc);

        check_eq("ram_en",   ram_en,   e_en);
        check_eq("ram_we",   ram_we,   e_en && t_wr);
        if (e_en) begin
            check_eq("ram_addr", ram_addr, t_addr);
            if (t_wr) check_eq("ram_wdata", ram_wdata, t_data);
        end
        check_eq("if_valid", if_valid, e_ifv);
        check_eq("mem_done", mem_done, e_md);
        if (e_ifv) check_eq("if_rdata", if_rdata, ref_mem[t_addr]);
        if (e_md && t_wr)  ref_mem[t_addr] = t_data;
        if (e_md && !t_wr) exp_mem_rdata = ref_mem[t_addr];
        check_eq("mem_rdata", mem_rdata, exp_mem_rdata);

        pf = mreq && !e_md;
        check_eq("pipe_freeze",   pipe_freeze,   pf);
        check_eq("IF_ID_loadbar", IF_ID_loadbar, pf);
        check_eq("pc_writebar",   pc_writebar,   pf || (if_req && !e_ifv));
        check_eq("if_bubble",     if_bubble,     if_req && !e_ifv && !pf);
`ifdef MEM_ARB_PERF_EN
        check_eq("fetch_cnt", fetch_stall_cnt, exp_fs);
        check_eq("mem_cnt",   mem_stall_cnt,   exp_ms);
        if ((pf || (if_req && !e_ifv)) && !pf && exp_fs < 65535) exp_fs++;
        if (pf && exp_ms < 65535) exp_ms++;
`endif
        // The arbiter is free when idle or in the completion cycle; the
        // request being completed is already served.
        if (!busy || (t_done == cyc)) begin
            busy = 1'b0;
            pi = if_req && !e_ifv;
            pm = mreq && !e_md;
            if (pi || pm) begin
                t_mem    = pm && !(last_mem && pi);
                last_mem = t_mem;
                t_wr     = t_mem && mem_wr;
                t_addr   = t_mem ? mem_addr : if_addr;
                t_data   = mem_wdata;
                t_issue  = cyc + 1;
                t_done   = cyc + LAT + 2;
                busy     = 1'b1;
            end
        end
        if_done_prev  = e_ifv;
        mem_done_prev = e_md;
    endtask

    // mode: 0 directed only, 1 random, 2 both restart at once, 3 IF restarts only
    task automatic step(input int mode);
        int op;
        @(posedge clk);
        #1;
        if (if_done_prev)  if_active  = 1'b0;
        if (mem_done_prev) mem_active = 1'b0;
        if (go_if) begin
            if_active = 1'b1; if_a = go_if_a; go_if = 1'b0;
        end
        if (go_mem) begin
            mem_active = 1'b1; m_rd = go_rd; m_wr = go_wr; m_a = go_m_a; m_d = go_m_d;
            go_mem = 1'b0;
        end
        if (!if_active && (mode == 2 || mode == 3 || (mode == 1 && $urandom_range(2, 0) != 0))) begin
            if_active = 1'b1;
            if_a      = ADDR_W'($urandom_range(15, 0));
        end
        if (!mem_active && (mode == 2 || (mode == 1 && $urandom_range(2, 0) == 0))) begin
            op = $urandom_range(2, 0);
            mem_active = 1'b1;
            m_rd = (op != 1);
            m_wr = (op != 0);
            m_a  = ADDR_W'($urandom_range(15, 0));
            m_d  = DATA_W'($urandom);
        end
        reset     = rst_val;
        if_req    = if_active;
        if_addr   = if_active ? if_a : ADDR_W'($urandom);
        mem_rd    = mem_active & m_rd;
        mem_wr    = mem_active & m_wr;
        mem_addr  = m_a;
        mem_wdata = mem_active ? m_d : DATA_W'($urandom);
        @(negedge clk);
        model_check();
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) step(mode);
    endtask

    task automatic start_mem(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        go_mem = 1'b1; go_rd = rd; go_wr = wr; go_m_a = a; go_m_d = d;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        for (int i = 0; i <= LAT; i++) begin
            dl_v[i] = 1'b0;
            dl_a[i] = '0;
        end
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            v = DATA_W'($urandom);
            ram_arr[i] = v;
            ref_mem[i] = v;
        end
        ram_arr[4] = 19'h1ABCD;
        ref_mem[4] = 19'h1ABCD;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0;

        rst_val = 1'b0;
        run(3, 0);
        rst_val = 1'b1;

        // Single fetch from 004.
        go_if = 1'b1; go_if_a = 12'h004;
        run(8, 0);
        check_eq("t1_if_rdata", if_rdata, 19'h1ABCD);

        // Store 00055 to 010, then load it back.
        start_mem(1'b0, 1'b1, 12'h010, 19'h00055);
        run(8, 0);
        start_mem(1'b1, 1'b0, 12'h010, 19'h00000);
        run(8, 0);
        check_eq("t2_mem_rdata", mem_rdata, 19'h00055);

        // Both requesters held together: alternating grants.
        run(40, 2);
        run(12, 0);

        // Reset during WAIT of a load; the held load reissues afterwards.
        start_mem(1'b1, 1'b0, 12'h010, 19'h00000);
        run(3, 0);
        rst_val = 1'b0;
        run(2, 0);
        rst_val = 1'b1;
        run(10, 0);
        check_eq("t4_mem_rdata", mem_rdata, 19'h00055);

        // rd and wr together act as a store; load data register untouched.
        start_mem(1'b1, 1'b1, 12'h010, 19'h71234);
        run(8, 0);
        check_eq("t5_mem_rdata_kept", mem_rdata, 19'h00055);
        start_mem(1'b1, 1'b0, 12'h010, 19'h00000);
        run(8, 0);
        check_eq("t5_load_back", mem_rdata, 19'h71234);

        // Randomized traffic, then drain.
        run(3000, 1);
        run(12, 0);

`ifdef MEM_ARB_PERF_EN
        // Long fetch-only stall until the fetch counter saturates.
        run(85000, 3);
        check_eq("perf_fetch_sat", fetch_stall_cnt, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
